// File: rtl/key_in_pio_if.sv
// Avalon-MM slave bus bundle for the push-button input port.
// The slave drives readdata; everything else comes from the bus master.
interface key_in_pio_if #(
  parameter int WIDTH = 4
);
  logic             chipselect;
  logic [2:0]       address;
  logic             read_n;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output chipselect, address, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/key_in_pio.sv
// Debounced active-low push-button input port with sticky press capture and
// a maskable level interrupt, exposed as an Avalon-MM slave.
module key_in_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             csi_clk,
  input  logic             csi_reset_n,
  key_in_pio_if.slave      avs,
  output logic             ins_irq,
  input  logic [WIDTH-1:0] coe_KEY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] stable_p2;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync_p1[i] != stable_p2[i]) && (cnt_p2[i] == CNT_LAST);
    end
  end

  // A press is an accepted change while the debounced level is still high.
  assign press = accept & stable_p2;
  assign wr_en = avs.chipselect && !avs.write_n;
  assign clr   = (wr_en && avs.address == 3'd2) ? avs.writedata : '0;

  // Stage p0/p1: two-flop synchroniser for the asynchronous pins
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= coe_KEY;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-key debounce, level must persist DEBOUNCE_CYCLES edges
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      stable_p2 <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (accept[i]) begin
          stable_p2[i] <= sync_p1[i];
          cnt_p2[i]    <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set has priority over a same-edge write-1-to-clear.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && avs.address == 3'd1) begin
        irq_mask <= avs.writedata;
      end
      edge_cap <= (edge_cap & ~clr) | press;
    end
  end

  assign ins_irq = |(edge_cap & irq_mask);

  always_comb begin
    avs.readdata = '0;
    if (avs.chipselect && !avs.read_n) begin
      case (avs.address)
        3'd0:    avs.readdata = stable_p2;
        3'd1:    avs.readdata = irq_mask;
        3'd2:    avs.readdata = edge_cap;
        3'd3:    avs.readdata = sync_p1;
        default: avs.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_in_pio.sv
// Bench for key_in_pio: directed vector table, hand-written corner sequences
// and random traffic, all checked against a window-based reference model.
module tb_key_in_pio;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] keys  = '1;
  logic         irq;

  key_in_pio_if #(.WIDTH(W)) bus ();

  key_in_pio #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4)
  ) dut (
    .csi_clk    (clk),
    .csi_reset_n(rst_n),
    .avs        (bus),
    .ins_irq    (irq),
    .coe_KEY    (keys)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a key's debounced level flips when the last D
  // synchronised samples all differ from it; sync output is pin delayed 2.
  logic [W-1:0] m_stable, m_mask, m_cap;
  logic [W-1:0] pin_hist[$];
  logic [W-1:0] s2_hist[$];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] s2, nxt, clr;
    if (!rst_n) begin
      m_stable = '1;
      m_mask   = '0;
      m_cap    = '0;
      pin_hist.delete();
      pin_hist.push_back('1);
      pin_hist.push_back('1);
      s2_hist.delete();
    end else begin
      s2 = pin_hist[pin_hist.size()-2];
      s2_hist.push_back(s2);
      if (s2_hist.size() > D) void'(s2_hist.pop_front());
      nxt = m_stable;
      if (s2_hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          bit all_new;
          all_new = 1'b1;
          foreach (s2_hist[j]) if (s2_hist[j][b] == m_stable[b]) all_new = 1'b0;
          if (all_new) nxt[b] = ~m_stable[b];
        end
      end
      clr = '0;
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 3'd1) m_mask = bus.writedata;
        if (bus.address == 3'd2) clr = bus.writedata;
      end
      m_cap    = (m_cap & ~clr) | (m_stable & ~nxt);
      m_stable = nxt;
      pin_hist.push_back(keys);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
    end
  end

  function automatic logic [W-1:0] m_read();
    if (!bus.chipselect || bus.read_n) return '0;
    case (bus.address)
      3'd0:    return m_stable;
      3'd1:    return m_mask;
      3'd2:    return m_cap;
      3'd3:    return pin_hist[pin_hist.size()-2];
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge, then compare against the model.
  task automatic step(input logic [W-1:0] k, input logic cs, input logic rn, input logic wn,
                      input logic [2:0] a, input logic [W-1:0] wd);
    @(negedge clk);
    keys           = k;
    bus.chipselect = cs;
    bus.read_n     = rn;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    #1;
    check("model_rdata", bus.readdata, m_read());
    check("model_irq", W'(irq), W'(|(m_cap & m_mask)));
  endtask

  task automatic rd(input logic [W-1:0] k, input logic [2:0] a);
    step(k, 1'b1, 1'b0, 1'b1, a, '0);
  endtask

  task automatic wr(input logic [W-1:0] k, input logic [2:0] a, input logic [W-1:0] wd);
    step(k, 1'b1, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [W-1:0] k);
    step(k, 1'b0, 1'b1, 1'b1, 3'd0, '0);
  endtask

  typedef struct {
    int           pre_idle;
    logic [W-1:0] k;
    logic         cs;
    logic         rn;
    logic         wn;
    logic [2:0]   a;
    logic [W-1:0] wd;
    logic [W-1:0] exp_rd;
    logic         exp_irq;
  } vec_t;

  function automatic vec_t vr(int n, logic [W-1:0] k, logic [2:0] a, logic [W-1:0] e, logic i);
    vec_t v = '{n, k, 1'b1, 1'b0, 1'b1, a, '0, e, i};
    return v;
  endfunction

  function automatic vec_t vw(int n, logic [W-1:0] k, logic [2:0] a, logic [W-1:0] wd, logic i);
    vec_t v = '{n, k, 1'b1, 1'b1, 1'b0, a, wd, '0, i};
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] k;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = '0;

    // Reset, bus decode, press latency, irq and mask flows.
    vt.push_back(vr(0, 4'hF, 3'd0, 4'hF, 1'b0));
    vt.push_back(vr(0, 4'hF, 3'd1, 4'h0, 1'b0));
    vt.push_back(vr(0, 4'hF, 3'd2, 4'h0, 1'b0));
    vt.push_back(vr(0, 4'hF, 3'd3, 4'hF, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd0, 4'hF, 1'b0));
    vt.push_back(vr(8, 4'hD, 3'd0, 4'hF, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd0, 4'hD, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd2, 4'h2, 1'b0));
    vt.push_back(vw(0, 4'hD, 3'd1, 4'h4, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd1, 4'h4, 1'b0));
    vt.push_back(vr(0, 4'h9, 3'd2, 4'h2, 1'b0));
    vt.push_back(vr(8, 4'h9, 3'd2, 4'h2, 1'b0));
    vt.push_back(vr(0, 4'h9, 3'd2, 4'h6, 1'b1));
    vt.push_back(vw(0, 4'h9, 3'd2, 4'h4, 1'b1));
    vt.push_back(vr(0, 4'h9, 3'd2, 4'h2, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd0, 4'h9, 1'b0));
    vt.push_back(vr(10, 4'hD, 3'd0, 4'hD, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd2, 4'h2, 1'b0));
    vt.push_back(vw(0, 4'hD, 3'd0, 4'hF, 1'b0));
    vt.push_back(vw(0, 4'hD, 3'd3, 4'hF, 1'b0));
    vt.push_back(vw(0, 4'hD, 3'd5, 4'hF, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd1, 4'h4, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd2, 4'h2, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd0, 4'hD, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd6, 4'h0, 1'b0));
    vt.push_back('{0, 4'hD, 1'b0, 1'b0, 1'b1, 3'd1, 4'h0, 4'h0, 1'b0});
    vt.push_back('{0, 4'hD, 1'b1, 1'b0, 1'b0, 3'd1, 4'hA, 4'h4, 1'b0});
    vt.push_back(vr(0, 4'hD, 3'd1, 4'hA, 1'b1));
    vt.push_back(vw(0, 4'hD, 3'd1, 4'h0, 1'b1));
    vt.push_back(vr(0, 4'hD, 3'd1, 4'h0, 1'b0));
    vt.push_back(vw(0, 4'hD, 3'd2, 4'h2, 1'b0));
    vt.push_back(vr(0, 4'hD, 3'd2, 4'h0, 1'b0));
    vt.push_back(vr(0, 4'hF, 3'd0, 4'hD, 1'b0));
    vt.push_back(vr(10, 4'hF, 3'd0, 4'hF, 1'b0));
    vt.push_back(vr(0, 4'hF, 3'd2, 4'h0, 1'b0));

    idle(4'hF);
    idle(4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      repeat (vt[i].pre_idle) idle(vt[i].k);
      step(vt[i].k, vt[i].cs, vt[i].rn, vt[i].wn, vt[i].a, vt[i].wd);
      check($sformatf("vec%0d_rdata", i), bus.readdata, vt[i].exp_rd);
      check($sformatf("vec%0d_irq", i), W'(irq), W'(vt[i].exp_irq));
    end

    // Bounce on key0: 5 low, 2 high, 5 low, then high; never accepted.
    for (int j = 0; j < 24; j++) begin
      k = ((j < 5) || (j >= 7 && j < 12)) ? 4'hE : 4'hF;
      rd(k, 3'd0);
      check("bounce_stable", bus.readdata, 4'hF);
    end
    rd(4'hF, 3'd2);
    check("bounce_cap", bus.readdata, 4'h0);

    // Write-1-to-clear of bit3 on the very edge that key3 is accepted.
    wr(4'hF, 3'd1, 4'h8);
    idle(4'h7);
    repeat (8) idle(4'h7);
    wr(4'h7, 3'd2, 4'h8);
    rd(4'h7, 3'd2);
    check("collide_cap", bus.readdata, 4'h8);
    check("collide_irq", W'(irq), W'(1'b1));
    wr(4'h7, 3'd2, 4'h8);
    repeat (12) idle(4'hF);
    wr(4'hF, 3'd1, 4'h0);
    rd(4'hF, 3'd2);
    check("collide_clear", bus.readdata, 4'h0);

    // Reset while key0 is mid-count: re-debounced from scratch afterwards.
    repeat (4) idle(4'hE);
    rst_n = 1'b0;
    idle(4'hE);
    idle(4'hE);
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      if (j % 2 == 1) begin
        rd(4'hE, 3'd0);
        check("rst_mid_stable", bus.readdata, 4'hF);
      end else begin
        rd(4'hE, 3'd2);
        check("rst_mid_cap", bus.readdata, 4'h0);
      end
    end
    rd(4'hE, 3'd2);
    check("rst_mid_capture", bus.readdata, 4'h1);
    repeat (12) idle(4'hF);
    wr(4'hF, 3'd2, 4'h1);

    // Random pins with varied hold lengths and random bus traffic.
    k = 4'hF;
    for (int j = 0; j < 3000; j++) begin
      logic         cs, rn, wn;
      logic [2:0]   a;
      logic [W-1:0] wd;
      if ($urandom_range(0, 9) == 0) k = W'($urandom);
      cs = ($urandom_range(0, 3) != 0);
      rn = $urandom_range(0, 1) == 1;
      wn = ($urandom_range(0, 3) != 0);
      a  = 3'($urandom);
      wd = W'($urandom);
      step(k, cs, rn, wn, a, wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
